mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared byte-addressable 16-bit memory. It sits between instruction fetch (port 0) and the load/store unit (port 1) and serialises their accesses onto one memory port. It models a configurable access latency, drives memory enable/write strobes, and returns read data with a completion pulse. Misaligned (odd) addresses are rejected without touching memory.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-port arbiter and sequencer for the shared 16-bit byte-addressable memory.
// Port 0 is instruction fetch and port 1 is the load/store unit. Each accepted
// access occupies the memory port for LATENCY cycles. The access cycle is the
// last of those cycles, and the owner receives a registered done pulse (plus
// err for an odd address) on the following cycle.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to let the port that was not
// granted last win on contention. When it is undefined, port 1 always wins.
module mem_port_arbiter #(
   parameter int LATENCY    = 2,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  wr0,
   input  logic                  wr1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [15:0]           wdata0,
   input  logic [15:0]           wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  done0,
   output logic                  done1,
   output logic                  err0,
   output logic                  err1,
   output logic [15:0]           rdata,
   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_wdata,
   input  logic [15:0]           mem_rdata
);

   // The count loaded at grant. It runs down to zero, and zero marks the access cycle.
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [3:0]      cnt;
   logic [3:0]      cnt_nxt;
   logic            owner;       // 0 = fetch port, 1 = load/store port
   logic            wr_q;
   logic            misalign_q;
   logic            win;         // port that would be granted this cycle
   logic            take;        // a grant happens this cycle
   logic            access;      // this cycle is the access cycle

`ifdef ARB_ROUND_ROBIN_EN
   logic            last_q;      // last granted port

   // Pick the winner. On contention, the port that was not granted last wins.
   always_comb begin
      win = req1;
      if (req0 && req1) begin
         win = ~last_q;
      end
   end

   // Record the last granted port. Reset makes port 1 win the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b0;
      end else if (take) begin
         last_q <= win;
      end
   end
`else
   // Pick the winner with fixed priority: port 1 beats port 0.
   always_comb begin
      win = req1;
   end
`endif

   // Compute the next state and the combinational strobes for grant and memory access.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      take      = 1'b0;
      access    = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               take      = 1'b1;
               gnt0      = ~win;
               gnt1      = win;
               cnt_nxt   = CNT_LOAD;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               access    = 1'b1;
               mem_en    = ~misalign_q;
               mem_wr    = wr_q & ~misalign_q;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Reset overrides everything. A pending access is abandoned, and no
      // write reaches memory in the reset cycle.
      if (rst) begin
         state_nxt = IDLE;
         cnt_nxt   = 4'd0;
         take      = 1'b0;
         access    = 1'b0;
         gnt0      = 1'b0;
         gnt1      = 1'b0;
         mem_en    = 1'b0;
         mem_wr    = 1'b0;
      end
   end

   // Register the state and the latency counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments, so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Latch the winner's request attributes at grant. They drive the memory port during BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= 1'b0;
         wr_q       <= 1'b0;
         misalign_q <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 16'd0;
      end else if (take) begin
         owner      <= win;
         wr_q       <= win ? wr1 : wr0;
         misalign_q <= win ? addr1[0] : addr0[0];
         mem_addr   <= win ? addr1 : addr0;
         mem_wdata  <= win ? wdata1 : wdata0;
      end
   end

   // Produce the completion pulses and capture read data on the access edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         err0  <= 1'b0;
         err1  <= 1'b0;
         rdata <= 16'd0;
      end else begin
         done0 <= access & ~owner;
         done1 <= access & owner;
         err0  <= access & ~owner & misalign_q;
         err1  <= access & owner & misalign_q;
         if (access && !wr_q && !misalign_q) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Instance u_dut uses LATENCY = 2 and
// instance u_dut_b uses LATENCY = 1. Each instance has its own behavioural
// memory. Expected values come from transaction-level reasoning: grant time,
// access at grant + LATENCY, done one cycle later, and a shadow memory image.
module tb_mem_port_arbiter;

   localparam int LAT   = 2;
   localparam int LAT_B = 1;
   localparam int AW    = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A signals
   logic          rst, req0, req1, wr0, wr1;
   logic [AW-1:0] addr0, addr1;
   logic [15:0]   wdata0, wdata1;
   logic          gnt0, gnt1, done0, done1, err0, err1;
   logic [15:0]   rdata;
   logic          mem_en, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata, mem_rdata;

   // Instance B signals (LATENCY = 1)
   logic          rst_b, req0_b, req1_b, wr0_b, wr1_b;
   logic [AW-1:0] addr0_b, addr1_b;
   logic [15:0]   wdata0_b, wdata1_b;
   logic          gnt0_b, gnt1_b, done0_b, done1_b, err0_b, err1_b;
   logic [15:0]   rdata_b;
   logic          mem_en_b, mem_wr_b;
   logic [AW-1:0] mem_addr_b;
   logic [15:0]   mem_wdata_b, mem_rdata_b;

   mem_port_arbiter #(.LATENCY(LAT), .ADDR_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata(rdata), .mem_en(mem_en),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.LATENCY(LAT_B), .ADDR_WIDTH(AW)) u_dut_b (
      .clk(clk), .rst(rst_b), .req0(req0_b), .req1(req1_b), .wr0(wr0_b),
      .wr1(wr1_b), .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b),
      .wdata1(wdata1_b), .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b),
      .done1(done1_b), .err0(err0_b), .err1(err1_b), .rdata(rdata_b),
      .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
   );

   // Behavioural memories: 256 words covering byte addresses 0x000..0x1FF.
   logic [15:0] mem   [0:255];
   logic [15:0] mem_b [0:255];
   logic [15:0] shadow[0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_idx;
   logic [15:0] pl_val;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (mem_en && mem_wr) mem[mem_addr[8:1]] <= mem_wdata;
   end
   always @(posedge clk) begin
      if (pl_en) mem_b[pl_idx] <= pl_val;
      else if (mem_en_b && mem_wr_b) mem_b[mem_addr_b[8:1]] <= mem_wdata_b;
   end
   assign mem_rdata   = mem[mem_addr[8:1]];
   assign mem_rdata_b = mem_b[mem_addr_b[8:1]];

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_rdata;

   function automatic logic [15:0] fill_val(input int i);
      return 16'(i * 257) ^ 16'h5A5A;
   endfunction

   // Advance to 2 time units after the next rising edge, which is the drive point.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic preload(input int idx, input logic [15:0] v);
      pl_en  = 1'b1;
      pl_idx = 8'(idx);
      pl_val = v;
      shadow[idx] = v;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic set_port(input int p, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
      if (p == 0) begin
         req0 = r; wr0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; wr1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0010; addr1 = 16'h0020;
      tick();
      #1;
      vectors++;
      if ({gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_wr} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_strobes got %b want 00000000",
                  {gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_wr});
      end
      vectors++;
      if (rdata !== 16'h0000) begin
         miscompares++; $display("FAIL reset_rdata got %h want 0000", rdata);
      end
      vectors++;
      if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_mem_regs got %h/%h want 0000/0000", mem_addr, mem_wdata);
      end
      tick();
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      exp_rdata = 16'h0000;
   endtask

   task automatic test_single_read();
      set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      #1;
      vectors++;
      if ({gnt0, gnt1, mem_en} !== 3'b100) begin
         miscompares++; $display("FAIL read_grant got %b want 100", {gnt0, gnt1, mem_en});
      end
      tick();
      set_port(0, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
      #1;
      vectors++;
      if ({gnt0, mem_en} !== 2'b00) begin
         miscompares++; $display("FAIL read_t1 got %b want 00", {gnt0, mem_en});
      end
      tick(); #1;
      vectors++;
      if ({mem_en, mem_wr} !== 2'b10 || mem_addr !== 16'h0010) begin
         miscompares++;
         $display("FAIL read_access got en/wr %b addr %h want 10 0010", {mem_en, mem_wr}, mem_addr);
      end
      tick(); #1;
      vectors++;
      if ({done0, err0, done1, mem_en} !== 4'b1000 || rdata !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL read_done got %b rdata %h want 1000 beef", {done0, err0, done1, mem_en}, rdata);
      end
      exp_rdata = 16'hBEEF;
      tick(); #1;
      vectors++;
      if (done0 !== 1'b0) begin
         miscompares++; $display("FAIL read_done_pulse got %b want 0", done0);
      end
   endtask

   task automatic test_write_read();
      int en_cnt = 0;
      set_port(1, 1'b1, 1'b1, 16'h0020, 16'h1234);
      #1;
      vectors++;
      if ({gnt0, gnt1} !== 2'b01) begin
         miscompares++; $display("FAIL write_grant got %b want 01", {gnt0, gnt1});
      end
      if (mem_en && mem_wr) en_cnt++;
      for (int c = 1; c <= LAT + 3; c++) begin
         tick();
         if (c == 1) set_port(1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
         #1;
         if (mem_en && mem_wr) begin
            en_cnt++;
            vectors++;
            if (mem_wdata !== 16'h1234 || mem_addr !== 16'h0020) begin
               miscompares++;
               $display("FAIL write_bus got %h@%h want 1234@0020", mem_wdata, mem_addr);
            end
         end
         if (c == LAT + 1) begin
            vectors++;
            if ({done1, err1} !== 2'b10 || rdata !== exp_rdata) begin
               miscompares++;
               $display("FAIL write_done got %b rdata %h want 10 %h", {done1, err1}, rdata, exp_rdata);
            end
         end
      end
      vectors++;
      if (en_cnt !== 1) begin
         miscompares++; $display("FAIL write_once got %0d strobes want 1", en_cnt);
      end
      vectors++;
      if (mem[16] !== 16'h1234) begin
         miscompares++; $display("FAIL write_mem got %h want 1234", mem[16]);
      end
      shadow[16] = 16'h1234;
      set_port(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      tick();
      set_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (LAT) tick();
      #1;
      vectors++;
      if (done0 !== 1'b1 || rdata !== 16'h1234) begin
         miscompares++; $display("FAIL readback got done %b rdata %h want 1 1234", done0, rdata);
      end
      exp_rdata = 16'h1234;
      tick();
   endtask

   task automatic test_contention();
      int gq_port[$];
      int gq_cyc[$];
      int n_exp;
      rst = 1'b1; tick(); rst = 1'b0;
      exp_rdata = 16'h0000;
      set_port(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      set_port(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
      for (int k = 0; k < 16; k++) begin
         #1;
         if (k == LAT + 1) begin
            vectors++;
            if (done1 !== 1'b1) begin
               miscompares++; $display("FAIL contend_done1 got %b want 1", done1);
            end
         end
         if (gnt0) begin gq_port.push_back(0); gq_cyc.push_back(k); end
         if (gnt1) begin gq_port.push_back(1); gq_cyc.push_back(k); end
         tick();
`ifdef ARB_ROUND_ROBIN_EN
         if (gq_port.size() >= 4) begin req0 = 1'b0; req1 = 1'b0; end
`else
         foreach (gq_port[i]) begin
            if (gq_port[i] == 0) req0 = 1'b0;
            else req1 = 1'b0;
         end
`endif
      end
`ifdef ARB_ROUND_ROBIN_EN
      n_exp = 4;
`else
      n_exp = 2;
`endif
      vectors++;
      if (gq_port.size() != n_exp) begin
         miscompares++; $display("FAIL contend_count got %0d want %0d", gq_port.size(), n_exp);
      end
      for (int i = 0; i < n_exp && i < gq_port.size(); i++) begin
         vectors++;
         // Winners alternate 1, 0, 1, 0 and are spaced LATENCY+1 apart.
         if (gq_port[i] != ((i % 2 == 0) ? 1 : 0) || gq_cyc[i] != i * (LAT + 1)) begin
            miscompares++;
            $display("FAIL contend_grant%0d got port %0d cyc %0d want port %0d cyc %0d",
                     i, gq_port[i], gq_cyc[i], (i % 2 == 0) ? 1 : 0, i * (LAT + 1));
         end
      end
      #1;
      vectors++;
      if (rdata !== 16'hBEEF) begin
         miscompares++; $display("FAIL contend_rdata got %h want beef", rdata);
      end
      exp_rdata = 16'hBEEF;
   endtask

   task automatic test_misaligned();
      logic en_seen = 1'b0;
      set_port(1, 1'b1, 1'b1, 16'h0021, 16'hDEAD);
      #1;
      vectors++;
      if (gnt1 !== 1'b1) begin
         miscompares++; $display("FAIL mis_grant got %b want 1", gnt1);
      end
      if (mem_en) en_seen = 1'b1;
      for (int c = 1; c <= LAT + 1; c++) begin
         tick();
         if (c == 1) set_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
         #1;
         if (mem_en) en_seen = 1'b1;
      end
      vectors++;
      if ({done1, err1} !== 2'b11 || rdata !== exp_rdata) begin
         miscompares++;
         $display("FAIL mis_done got %b rdata %h want 11 %h", {done1, err1}, rdata, exp_rdata);
      end
      vectors++;
      if (en_seen !== 1'b0 || mem[16] !== 16'h1234) begin
         miscompares++; $display("FAIL mis_no_access got en %b mem %h want 0 1234", en_seen, mem[16]);
      end
      tick(); #1;
      vectors++;
      if ({done1, err1} !== 2'b00) begin
         miscompares++; $display("FAIL mis_pulse got %b want 00", {done1, err1});
      end
   endtask

   task automatic test_reset_mid_access();
      set_port(1, 1'b1, 1'b1, 16'h0030, 16'h5555);
      tick();
      set_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (LAT - 1) tick();
      // Access cycle of the write: assert reset and raise a request that must be ignored.
      rst = 1'b1;
      set_port(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
      #1;
      vectors++;
      if ({mem_en, mem_wr, gnt0} !== 3'b000) begin
         miscompares++; $display("FAIL rstmid_strobes got %b want 000", {mem_en, mem_wr, gnt0});
      end
      tick();
      rst = 1'b0;
      #1;
      vectors++;
      if ({done1, err1} !== 2'b00 || rdata !== 16'h0000 || mem_addr !== 16'h0000 ||
          mem_wdata !== 16'h0000) begin
         miscompares++;
         $display("FAIL rstmid_outputs got %b %h %h %h want 00 0000 0000 0000",
                  {done1, err1}, rdata, mem_addr, mem_wdata);
      end
      vectors++;
      if (mem[24] !== 16'hAAAA) begin
         miscompares++; $display("FAIL rstmid_mem got %h want aaaa", mem[24]);
      end
      vectors++;
      if (gnt0 !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_regrant got %b want 1", gnt0);
      end
      tick();
      set_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (LAT - 1) tick();
      #1;
      vectors++;
      if (done0 !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_early_done got %b want 0", done0);
      end
      tick(); #1;
      vectors++;
      if (done0 !== 1'b1 || rdata !== 16'hAAAA) begin
         miscompares++; $display("FAIL rstmid_next got done %b rdata %h want 1 aaaa", done0, rdata);
      end
      exp_rdata = 16'hAAAA;
      tick();
   endtask

   task automatic test_latency1();
      logic [15:0] addrs [3];
      logic [15:0] vals  [3];
      int n_g = 0;
      int n_d = 0;
      addrs[0] = 16'h0010; vals[0] = 16'hBEEF;
      addrs[1] = 16'h0030; vals[1] = 16'hAAAA;
      addrs[2] = 16'h0040; vals[2] = fill_val(32);
      req0_b = 1'b1; addr0_b = addrs[0];
      for (int k = 0; k < 10; k++) begin
         #1;
         if (gnt0_b) begin
            vectors++;
            if (k != n_g * (LAT_B + 1)) begin
               miscompares++;
               $display("FAIL lat1_grant%0d got cyc %0d want %0d", n_g, k, n_g * (LAT_B + 1));
            end
            n_g++;
         end
         if (done0_b) begin
            vectors++;
            if (n_d > 2 || k != (n_d + 1) * (LAT_B + 1) || rdata_b !== vals[n_d % 3]) begin
               miscompares++;
               $display("FAIL lat1_done%0d got cyc %0d rdata %h want cyc %0d rdata %h",
                        n_d, k, rdata_b, (n_d + 1) * (LAT_B + 1), vals[n_d % 3]);
            end
            n_d++;
         end
         tick();
         if (n_g >= 3) req0_b = 1'b0;
         else addr0_b = addrs[n_g];
      end
      vectors++;
      if (n_g != 3 || n_d != 3) begin
         miscompares++; $display("FAIL lat1_count got %0d/%0d want 3/3", n_g, n_d);
      end
   endtask

   task automatic test_random();
      localparam int N = 600;
      int          pst [2];          // 0 free, 1 requesting, 2 waiting for done
      int          pdone [2];
      int          free_at = 0;
      int          acc_cyc = -1;
      int          done_cyc = -1;
      int          acc_port = 0;
      int          last = 0;
      int          w;
      int          bad = 0;
      logic        acc_mis = 1'b0, acc_wr = 1'b0;
      logic [15:0] acc_addr = '0, acc_wdata = '0, acc_rval = '0;
      logic [15:0] ref_mem [0:255];
      logic [15:0] a;
      logic [15:0] g_addr, g_wdata;
      logic        g_wr;
      logic        e_en, e_d0, e_d1;
      foreach (shadow[i]) ref_mem[i] = shadow[i];
      pst[0] = 0; pst[1] = 0; pdone[0] = 0; pdone[1] = 0;
      set_port(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_port(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      rst = 1'b1; tick(); rst = 1'b0;
      exp_rdata = 16'h0000;
      for (int k = 0; k < N; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (pst[p] == 2 && k >= pdone[p]) pst[p] = 0;
            if (pst[p] == 2) begin
               set_port(p, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
            end else if (pst[p] == 0) begin
               if (k < N - 20 && $urandom_range(2) == 0) begin
                  a = 16'($urandom_range(255) * 2) | 16'($urandom_range(3) == 0);
                  set_port(p, 1'b1, 1'($urandom), a, 16'($urandom));
                  pst[p] = 1;
               end else begin
                  set_port(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
               end
            end
         end
         #1;
         if (k == done_cyc && !acc_mis && !acc_wr) exp_rdata = acc_rval;
         e_en = (k == acc_cyc) && !acc_mis;
         e_d0 = (k == done_cyc) && (acc_port == 0);
         e_d1 = (k == done_cyc) && (acc_port == 1);
         vectors++;
         if ({mem_en, mem_wr} !== {e_en, e_en & acc_wr}) begin
            miscompares++;
            $display("FAIL rnd_mem_strobe cyc %0d got %b want %b", k, {mem_en, mem_wr}, {e_en, e_en & acc_wr});
         end
         if (e_en) begin
            vectors++;
            if (mem_addr !== acc_addr || (acc_wr && mem_wdata !== acc_wdata)) begin
               miscompares++;
               $display("FAIL rnd_mem_bus cyc %0d got %h/%h want %h/%h", k, mem_addr, mem_wdata, acc_addr, acc_wdata);
            end
         end
         vectors++;
         if ({done0, done1, err0, err1} !== {e_d0, e_d1, e_d0 & acc_mis, e_d1 & acc_mis}) begin
            miscompares++;
            $display("FAIL rnd_done cyc %0d got %b want %b", k, {done0, done1, err0, err1},
                     {e_d0, e_d1, e_d0 & acc_mis, e_d1 & acc_mis});
         end
         vectors++;
         if (rdata !== exp_rdata) begin
            miscompares++; $display("FAIL rnd_rdata cyc %0d got %h want %h", k, rdata, exp_rdata);
         end
         // Arbitration: free once the previous access has completed.
         w = -1;
         if (k >= free_at && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
               w = (last == 1) ? 0 : 1;
`else
               w = 1;
`endif
            end else begin
               w = req1 ? 1 : 0;
            end
         end
         vectors++;
         if ({gnt0, gnt1} !== {w == 0, w == 1}) begin
            miscompares++;
            $display("FAIL rnd_grant cyc %0d got %b want %b", k, {gnt0, gnt1}, {w == 0, w == 1});
         end
         if (w >= 0) begin
            g_addr  = (w == 1) ? addr1 : addr0;
            g_wdata = (w == 1) ? wdata1 : wdata0;
            g_wr    = (w == 1) ? wr1 : wr0;
            acc_cyc   = k + LAT;
            done_cyc  = k + LAT + 1;
            free_at   = done_cyc;
            acc_port  = w;
            acc_mis   = g_addr[0];
            acc_wr    = g_wr;
            acc_addr  = g_addr;
            acc_wdata = g_wdata;
            if (!acc_mis) begin
               if (g_wr) ref_mem[g_addr[8:1]] = g_wdata;
               else acc_rval = ref_mem[g_addr[8:1]];
            end
            pst[w]   = 2;
            pdone[w] = done_cyc;
            last     = w;
         end
         tick();
      end
      foreach (ref_mem[i]) if (mem[i] !== ref_mem[i]) bad++;
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL rnd_mem_image got %0d differing words want 0", bad);
      end
   endtask

   initial begin
      rst = 1'b1; rst_b = 1'b1;
      req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      req0_b = 1'b0; req1_b = 1'b0; wr0_b = 1'b0; wr1_b = 1'b0;
      addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
      exp_rdata = 16'h0000;
      #2;
      for (int i = 0; i < 256; i++) preload(i, fill_val(i));
      preload(8, 16'hBEEF);
      preload(24, 16'hAAAA);
      rst_b = 1'b0;
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_misaligned();
      test_reset_mid_access();
      test_latency1();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
